// File: rtl/nexys4ddr_keypad.sv
// ---------------------------------------------------------------------------------------------
// nexys4ddr_keypad
//
// Scanner and debouncer for a 4x4 matrix keypad (Pmod KYPD style). One column strobe is driven
// low at a time; the pulled-up rows are sampled through a 2-flop synchronizer. A "frame" is one
// full sweep of the four columns. A frame is accepted as the new debounced key state once it has
// been seen unchanged for DEBOUNCE consecutive frames. Newly pressed keys are turned into events
// and handed out one at a time, lowest key index first, over a valid/ready interface.
//
// Parameters
//   FREQ      clk frequency in Hz
//   COL_RATE  column strobe rate in Hz (one column advance every FREQ/COL_RATE cycles)
//   DEBOUNCE  identical consecutive frames needed to accept a change (1..15)
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   COL[3:0]   active-low column strobe to the keypad
//   ROW[3:0]   asynchronous row sense, low = key closed
//   keys[15:0] debounced key state, bit col*4+row, 1 = pressed
//   key_valid  a press event is being presented
//   key_code   index (col*4+row) of the presented press
//   key_ready  consumer accepts the presented event
// ---------------------------------------------------------------------------------------------
module nexys4ddr_keypad #(
   parameter int unsigned FREQ     = 100000000,
   parameter int unsigned COL_RATE = 4000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  COL,
   input  logic [3:0]  ROW,
   output logic [15:0] keys,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready
);

   localparam int unsigned Period    = FREQ / COL_RATE;
   localparam int unsigned CntW      = (Period > 1) ? $clog2(Period) : 1;
   localparam logic [CntW-1:0] CntReload = CntW'(Period - 1);
   localparam logic [3:0] StableMax = 4'(DEBOUNCE - 1);

   // ---------------------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------------------
   logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [3:0]      col_q, col_d;
   logic [3:0]      row_meta_q, row_meta_d;
   logic [3:0]      row_sync_q, row_sync_d;
   logic [15:0]     frame_q, frame_d;
   logic [15:0]     last_frame_q, last_frame_d;
   logic [3:0]      stable_cnt_q, stable_cnt_d;
   logic            load_q, load_d;
   logic [15:0]     keys_q, keys_d;
   logic [15:0]     pending_q, pending_d;
   logic            key_valid_q, key_valid_d;
   logic [3:0]      key_code_q, key_code_d;

   // ---------------------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------------------
   logic        tick;
   logic        frame_done;
   logic        frame_same;
   logic [15:0] frame_new;
   logic [15:0] pend_set;
   logic [15:0] pend_clr;
   logic [3:0]  lowest_idx;
   logic        pend_any;
   logic        out_accept;

   assign tick       = (tick_cnt_q == '0);
   assign frame_done = tick && (col_idx_q == 2'd3);
   assign frame_same = (frame_new == last_frame_q);
   assign pend_any   = |pending_q;
   // The output slot can take a new event when it is empty or being consumed this cycle.
   assign out_accept = !key_valid_q || key_ready;

   // Frame as it will look once the current column's sample is merged in.
   always_comb begin
      frame_new = frame_q;
      frame_new[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
   end

   // Lowest set pending index; scanning downwards leaves the smallest index last.
   always_comb begin
      lowest_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowest_idx = 4'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Strobe timing, synchronizer and frame capture
   // ---------------------------------------------------------------------------------------
   always_comb begin
      tick_cnt_d = tick ? CntReload : (tick_cnt_q - CntW'(1));
      col_idx_d  = tick ? (col_idx_q + 2'd1) : col_idx_q;
      // COL is registered from the next index so the strobe lines never glitch.
      col_d      = ~(4'b0001 << col_idx_d);
      row_meta_d = ROW;
      row_sync_d = row_meta_q;
      frame_d    = tick ? frame_new : frame_q;
   end

   // ---------------------------------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------------------------------
   always_comb begin
      last_frame_d = last_frame_q;
      stable_cnt_d = stable_cnt_q;
      load_d       = 1'b0;
      if (frame_done) begin
         last_frame_d = frame_new;
         if (frame_same) begin
            stable_cnt_d = (stable_cnt_q == StableMax) ? stable_cnt_q : (stable_cnt_q + 4'd1);
         end else begin
            stable_cnt_d = 4'd0;
         end
         // With DEBOUNCE = 1 every frame is accepted as soon as it completes.
         load_d = (DEBOUNCE == 1) || (frame_same && (stable_cnt_d == StableMax));
      end
   end

   // ---------------------------------------------------------------------------------------
   // Key state and press events. last_frame_q holds the accepted frame one cycle after the
   // completion that raised load_q.
   // ---------------------------------------------------------------------------------------
   always_comb begin
      keys_d   = keys_q;
      pend_set = 16'h0000;
      if (load_q) begin
         keys_d   = last_frame_q;
         // Only 0->1 transitions become events; releases just update keys.
         pend_set = last_frame_q & ~keys_q;
      end
   end

   always_comb begin
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
      pend_clr    = 16'h0000;
      if (out_accept) begin
         if (pend_any) begin
            key_valid_d = 1'b1;
            key_code_d  = lowest_idx;
            pend_clr    = 16'h0001 << lowest_idx;
         end else begin
            key_valid_d = 1'b0;
         end
      end
      // Clear before set: a key re-pressed in the cycle it is handed out stays pending.
      pending_d = (pending_q & ~pend_clr) | pend_set;
   end

   // ---------------------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q   <= CntReload;
         col_idx_q    <= 2'd0;
         col_q        <= 4'b1110;
         row_meta_q   <= 4'hF;
         row_sync_q   <= 4'hF;
         frame_q      <= 16'h0000;
         last_frame_q <= 16'h0000;
         stable_cnt_q <= 4'd0;
         load_q       <= 1'b0;
         keys_q       <= 16'h0000;
         pending_q    <= 16'h0000;
         key_valid_q  <= 1'b0;
         key_code_q   <= 4'd0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         col_idx_q    <= col_idx_d;
         col_q        <= col_d;
         row_meta_q   <= row_meta_d;
         row_sync_q   <= row_sync_d;
         frame_q      <= frame_d;
         last_frame_q <= last_frame_d;
         stable_cnt_q <= stable_cnt_d;
         load_q       <= load_d;
         keys_q       <= keys_d;
         pending_q    <= pending_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
      end
   end

   assign COL       = col_q;
   assign keys      = keys_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule

// File: doc/nexys4ddr_keypad.md
NEXYS4DDR_KEYPAD -- requirements
Module: nexys4ddr_keypad

Interface
REQ-001: The block SHALL have parameter FREQ, default 100000000, meaning clk frequency in Hz.
REQ-002: The block SHALL have parameter COL_RATE, default 4000, meaning column strobe rate in Hz.
REQ-003: The block SHALL have parameter DEBOUNCE, default 4, meaning identical consecutive frames required to accept a change (legal range 1..15).
REQ-004: The block SHALL have port clk, input, 1 bit: clock.
REQ-005: The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006: The block SHALL have port COL, output, 4 bits: active-low column strobe to the 4x4 keypad.
REQ-007: The block SHALL have port ROW, input, 4 bits: asynchronous row sense, pulled up externally, low = key closed.
REQ-008: The block SHALL have port keys, output, 16 bits: debounced key state, bit col*4+row, 1 = pressed.
REQ-009: The block SHALL have port key_valid, output, 1 bit: a press event is presented.
REQ-010: The block SHALL have port key_code, output, 4 bits: index (col*4+row) of the presented press.
REQ-011: The block SHALL have port key_ready, input, 1 bit: consumer accepts the event.

Function
REQ-012: The block SHALL derive period P = FREQ/COL_RATE clk cycles and generate a single-cycle tick every P cycles using a clk-domain down-counter; it SHALL NOT use any derived clock.
REQ-013: The block SHALL pass ROW through a 2-flop synchronizer before use.
REQ-014: The block SHALL keep a 2-bit col_idx and drive COL = ~(1 << col_idx); exactly one COL bit SHALL be low at any time.
REQ-015: On each tick, the block SHALL store ~row_sync into frame bits [col_idx*4 +: 4], then increment col_idx with wrap 3->0.
REQ-016: A frame SHALL complete on the tick where col_idx = 3.
REQ-017: On frame completion, if the frame equals last_frame, stable_cnt SHALL increment, saturating at DEBOUNCE-1; otherwise stable_cnt SHALL become 0.
REQ-018: On frame completion, last_frame SHALL take the new frame.
REQ-019: keys SHALL be loaded with the frame in the cycle after a completion at which the frame equals last_frame and the post-update stable_cnt = DEBOUNCE-1. For DEBOUNCE=1, keys SHALL load on every completion.
REQ-020: In the same cycle keys loads, the block SHALL set pending |= new & ~keys_old.
REQ-021: Output register: when key_valid = 0 or (key_valid and key_ready), and pending is non-zero, the block SHALL load key_code with the lowest set pending index, assert key_valid, and clear that pending bit; key_valid SHALL rise one cycle after pending is set.
REQ-022: If pending is empty at handshake, key_valid SHALL drop the next cycle.
REQ-023: While key_valid = 1 and key_ready = 0, key_valid and key_code SHALL hold stable.
REQ-024: Releases SHALL update keys only and SHALL generate no event.
REQ-025: When a pending clear and a pending set hit the same bit in one cycle, the clear SHALL apply first and the set SHALL win.
REQ-026: The block SHALL merge repeated presses of an already-pending key (no queue overflow is possible).
REQ-027: Multiple simultaneous new presses SHALL be emitted in ascending index order, one per accepted handshake.

Reset
REQ-028: Under rst, the block SHALL set COL = 4'b1110, col_idx = 0, the tick counter to P-1, frame, last_frame, keys and pending to 0, stable_cnt to 0, key_valid = 0, and key_code = 0.
REQ-029: Reset mid-operation SHALL discard pending events and any partial frame; keys held through reset SHALL be re-reported as presses after debounce.

Verification (FREQ=400, COL_RATE=100, P=4, DEBOUNCE=2)
REQ-030: Scenario -- reset, no keys: COL SHALL step 1110,1101,1011,0111,1110 every 4 cycles; keys = 0 and key_valid never asserts.
REQ-031: Scenario -- key 6 (col 1, row 2) held from reset with key_ready = 1: key_valid SHALL pulse once with key_code = 6 after 2 identical frames; keys = 16'h0040.
REQ-032: Scenario -- keys 9 and 3 pressed within one frame, key_ready = 0 for 50 cycles, then 1: the bench SHALL see key_code = 3 held for 50 cycles, then 9, then key_valid = 0.
REQ-033: Scenario -- key 0 bouncing, toggling every frame for 6 frames, then stable: keys SHALL remain 0 during the bounce, and exactly one event with key_code = 0 SHALL occur after stabilisation.
REQ-034: Scenario -- rst asserted while key_valid = 1 and pending is non-zero: key_valid = 0 and pending = 0 the next cycle, with no stale code after release.
REQ-035: Scenario -- key 15 press, release, re-press while its first event is still unaccepted: the bench SHALL see exactly two events with key_code = 15.
